// File: rtl/mdu_sequencer.sv
// Purpose: iterative RV32M multiply/divide unit with its control sequencer (radix-2 shift-add / restoring divide).
// Latency: accept in cycle 0, done_o in cycle 34 (fast path for div-by-zero / signed overflow: cycle 2).
// Backpressure: one op at a time; stall_o holds the pipeline while busy, req_i is ignored outside IDLE.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i, kill_i         start request (IDLE only), flush (aborts, wins over req_i)
//   mdu_op_i              op code (mdu_pkg encodings), captured with req_i
//   operand_a_i/_b_i      rs1 / rs2
//   busy_o, stall_o       not-IDLE, combinational pipeline stall
//   done_o, result_o      one-cycle completion strobe, registered result held until next completion

package mdu_pkg;
   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;
endpackage

module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int MDU_OP_WIDTH = 3
)
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   input  logic                    kill_i,
   input  logic [MDU_OP_WIDTH-1:0] mdu_op_i,
   input  logic [31:0]             operand_a_i,
   input  logic [31:0]             operand_b_i,
   output logic                    busy_o,
   output logic                    stall_o,
   output logic                    done_o,
   output logic [31:0]             result_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  r_state;
   logic [2:0]  r_op;
   logic [31:0] r_a_mag;
   logic [31:0] r_b_mag;
   logic        r_a_neg;
   logic        r_b_neg;
   logic        r_div0;
   logic        r_ovf;
   logic [4:0]  r_cnt;
   logic [63:0] r_acc;     // product accumulator, or {remainder, quotient} when dividing
   logic [31:0] r_result;

   // ---------------- request decode (IDLE capture) ----------------
   logic [2:0]  w_op;
   logic        w_is_div;
   logic        w_a_sgn;
   logic        w_b_sgn;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_div0;
   logic        w_ovf;
   logic        w_accept;

   assign w_op     = mdu_op_i[2:0];
   assign w_is_div = w_op[2];
   assign w_a_sgn  = (w_op == MDU_MULH) | (w_op == MDU_MULHSU) | (w_op == MDU_DIV) | (w_op == MDU_REM);
   assign w_b_sgn  = (w_op == MDU_MULH) | (w_op == MDU_DIV) | (w_op == MDU_REM);
   assign w_a_neg  = w_a_sgn & operand_a_i[31];
   assign w_b_neg  = w_b_sgn & operand_b_i[31];
   assign w_a_mag  = w_a_neg ? (~operand_a_i + 32'd1) : operand_a_i;
   assign w_b_mag  = w_b_neg ? (~operand_b_i + 32'd1) : operand_b_i;
   assign w_div0   = w_is_div & (operand_b_i == 32'd0);
   // only signed divides (DIV/REM) have w_a_sgn set among the divide ops
   assign w_ovf    = w_is_div & w_a_sgn & (operand_a_i == 32'h8000_0000) & (operand_b_i == 32'hFFFF_FFFF);
   assign w_accept = (r_state == S_IDLE) & req_i & ~kill_i;

   // ---------------- one iteration ----------------
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   logic [32:0] w_div_rem;
   logic        w_div_ge;
   logic [31:0] w_div_diff;
   logic [63:0] w_div_next;

   // shift-add: add |B| into the high word when the current multiplier bit is set, then shift right
   assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b_mag} : 33'd0);
   assign w_mul_next = {w_mul_sum, r_acc[31:1]};

   // restoring divide: remainder after the left shift needs 33 bits for the compare
   assign w_div_rem  = r_acc[63:31];
   assign w_div_ge   = (w_div_rem >= {1'b0, r_b_mag});
   assign w_div_diff = w_div_rem[31:0] - r_b_mag;   // fits in 32 bits whenever w_div_ge
   assign w_div_next = {(w_div_ge ? w_div_diff : w_div_rem[31:0]), r_acc[30:0], w_div_ge};

   // ---------------- sign fix-up and word select ----------------
   logic [63:0] w_prod;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic [31:0] w_a_orig;
   logic [31:0] w_fix_res;

   assign w_prod   = (r_a_neg ^ r_b_neg) ? (~r_acc + 64'd1) : r_acc;
   assign w_quot   = (r_a_neg ^ r_b_neg) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
   assign w_rem    = r_a_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
   assign w_a_orig = r_a_neg ? (~r_a_mag + 32'd1) : r_a_mag;   // rebuilds A for remainder-by-zero

   always_comb begin
      w_fix_res = 32'd0;
      case (r_op)
         MDU_MUL:                        w_fix_res = w_prod[31:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod[63:32];
         MDU_DIV, MDU_DIVU:              w_fix_res = r_div0 ? 32'hFFFF_FFFF :
                                                     r_ovf  ? 32'h8000_0000 : w_quot;
         MDU_REM, MDU_REMU:              w_fix_res = r_div0 ? w_a_orig :
                                                     r_ovf  ? 32'd0 : w_rem;
         default:                        w_fix_res = 32'd0;
      endcase
   end

   // ---------------- sequencer ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_op     <= 3'd0;
         r_a_mag  <= 32'd0;
         r_b_mag  <= 32'd0;
         r_a_neg  <= 1'b0;
         r_b_neg  <= 1'b0;
         r_div0   <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= 5'd0;
         r_acc    <= 64'd0;
         r_result <= 32'd0;
      end else if (kill_i) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_i) begin
                  r_op    <= w_op;
                  r_a_mag <= w_a_mag;
                  r_b_mag <= w_b_mag;
                  r_a_neg <= w_a_neg;
                  r_b_neg <= w_b_neg;
                  r_div0  <= w_div0;
                  r_ovf   <= w_ovf;
                  r_cnt   <= 5'd0;
                  r_acc   <= {32'd0, w_a_mag};
                  r_state <= (w_div0 | w_ovf) ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               r_acc <= r_op[2] ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_result <= w_fix_res;
               r_state  <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o   = (r_state != S_IDLE);
   assign stall_o  = w_accept | (r_state == S_CALC) | (r_state == S_FIX);
   assign done_o   = (r_state == S_DONE);
   assign result_o = r_result;

endmodule
